// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: datapath widths and the
// write-back stage state encoding.
package arm_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage : arm_pkg

// File: rtl/wb_timeout_counter.sv
// Saturating 8-bit wait counter for pending loads; expired is high once
// the count reaches TIMEOUT_CYCLES-1.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_r;

  assign expired = (count_r == 8'(TIMEOUT_CYCLES - 1));

  // Count register: clear wins, otherwise increment until the expiry compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (en && !expired) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule : wb_timeout_counter

// File: rtl/wb_stage.sv
// Write-back stage: registers MEM-stage results and waits on variable-latency
// loads with a timeout. Optional macro WB_FORWARD_EN exposes the pending load.
module wb_stage
  import arm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_valid,
  input  logic                  MEM_WB_EN,
  input  logic                  MEM_R_EN,
  input  logic [REG_ADDR_W-1:0] MEM_Dest,
  input  logic [DATA_W-1:0]     ALU_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  stall,
  output logic                  load_err,
  output logic                  WB_WB_EN,
  output logic [REG_ADDR_W-1:0] WB_Dest,
  output logic [DATA_W-1:0]     WB_Value
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_pend,
  output logic [REG_ADDR_W-1:0] fwd_pend_dest
`endif
);

  wb_state_t             state_r, state_nxt_s;
  logic                  stall_r, load_err_r, wb_en_r;
  logic [REG_ADDR_W-1:0] wb_dest_r;
  logic [DATA_W-1:0]     wb_value_r;
  logic                  pend_en_r;
  logic [REG_ADDR_W-1:0] pend_dest_r;

  logic                  wb_en_nxt_s, load_err_nxt_s, pend_en_nxt_s;
  logic [REG_ADDR_W-1:0] wb_dest_nxt_s, pend_dest_nxt_s;
  logic [DATA_W-1:0]     wb_value_nxt_s;
  logic                  cnt_clr_s, cnt_en_s, cnt_expired_s;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .expired (cnt_expired_s)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      stall_r     <= 1'b0;
      load_err_r  <= 1'b0;
      wb_en_r     <= 1'b0;
      wb_dest_r   <= '0;
      wb_value_r  <= '0;
      pend_en_r   <= 1'b0;
      pend_dest_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      stall_r     <= (state_nxt_s == LOAD_WAIT);
      load_err_r  <= load_err_nxt_s;
      wb_en_r     <= wb_en_nxt_s;
      wb_dest_r   <= wb_dest_nxt_s;
      wb_value_r  <= wb_value_nxt_s;
      pend_en_r   <= pend_en_nxt_s;
      pend_dest_r <= pend_dest_nxt_s;
    end
  end

  // Next-state: a load without same-cycle data parks in LOAD_WAIT
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (MEM_valid && MEM_R_EN && !mem_rvalid) begin
          state_nxt_s = LOAD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid || cnt_expired_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOAD_WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next output values; data arriving on the timeout cycle takes priority
  always_comb begin
    wb_en_nxt_s     = 1'b0;
    wb_dest_nxt_s   = wb_dest_r;
    wb_value_nxt_s  = wb_value_r;
    load_err_nxt_s  = 1'b0;
    pend_en_nxt_s   = pend_en_r;
    pend_dest_nxt_s = pend_dest_r;
    cnt_clr_s       = 1'b0;
    cnt_en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (MEM_valid) begin
          if (!MEM_R_EN) begin
            wb_en_nxt_s    = MEM_WB_EN;
            wb_dest_nxt_s  = MEM_Dest;
            wb_value_nxt_s = ALU_result;
          end else if (mem_rvalid) begin
            wb_en_nxt_s    = MEM_WB_EN;
            wb_dest_nxt_s  = MEM_Dest;
            wb_value_nxt_s = mem_rdata;
          end else begin
            pend_en_nxt_s   = MEM_WB_EN;
            pend_dest_nxt_s = MEM_Dest;
            cnt_clr_s       = 1'b1;
          end
        end else begin
          wb_en_nxt_s = 1'b0;
        end
      end
      LOAD_WAIT: begin
        cnt_en_s = 1'b1;
        if (mem_rvalid) begin
          wb_en_nxt_s     = pend_en_r;
          wb_dest_nxt_s   = pend_dest_r;
          wb_value_nxt_s  = mem_rdata;
          pend_en_nxt_s   = 1'b0;
          pend_dest_nxt_s = '0;
        end else if (cnt_expired_s) begin
          load_err_nxt_s  = 1'b1;
          pend_en_nxt_s   = 1'b0;
          pend_dest_nxt_s = '0;
        end else begin
          wb_en_nxt_s = 1'b0;
        end
      end
      default: begin
        pend_en_nxt_s   = 1'b0;
        pend_dest_nxt_s = '0;
      end
    endcase
  end

  assign stall    = stall_r;
  assign load_err = load_err_r;
  assign WB_WB_EN = wb_en_r;
  assign WB_Dest  = wb_dest_r;
  assign WB_Value = wb_value_r;

`ifdef WB_FORWARD_EN
  // pend_dest_r is cleared on every exit from LOAD_WAIT, so it reads 0 in IDLE
  assign fwd_pend      = stall_r;
  assign fwd_pend_dest = pend_dest_r;
`endif

endmodule : wb_stage

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the ARM pipeline. Registers results leaving the MEM stage and selects ALU result or load data as write-back value. Drives the register-file write port (`WB_WB_EN`, `WB_Dest`, `WB_Value`) consumed by the ID stage. Handles variable-latency data-memory loads with a wait state machine, a back-pressure stall and a load timeout.

## Interface
- `TIMEOUT_CYCLES`, 15, max cycles spent in `LOAD_WAIT` before the load is abandoned (1..255).
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_valid`  in  1  MEM stage presents an instruction this cycle.
- `MEM_WB_EN`  in  1  instruction writes a register.
- `MEM_R_EN`  in  1  instruction is a load.
- `MEM_Dest`  in  4  destination register.
- `ALU_result`  in  32  ALU result / load address-path value.
- `mem_rdata`  in  32  data-memory read data.
- `mem_rvalid`  in  1  `mem_rdata` valid this cycle.
- `stall`  out  1  upstream must hold its instruction.
- `load_err`  out  1  one-cycle pulse: load timed out.
- `WB_WB_EN`  out  1  register-file write enable.
- `WB_Dest`  out  4  register-file write address.
- `WB_Value`  out  32  register-file write data.

## Operation
- States: `IDLE`, `LOAD_WAIT`. Reset → `IDLE`. Every output is 0 at reset, counter is 0.
- `stall` = (state == `LOAD_WAIT`), Moore.
- In `IDLE` with `MEM_valid`=1:
  - `MEM_R_EN`=0 → next cycle `WB_WB_EN`=`MEM_WB_EN`, `WB_Dest`=`MEM_Dest`, `WB_Value`=`ALU_result`.
  - `MEM_R_EN`=1, `mem_rvalid`=1 → next cycle same, with `WB_Value`=`mem_rdata`.
  - `MEM_R_EN`=1, `mem_rvalid`=0 → latch `MEM_WB_EN`/`MEM_Dest`, clear counter, go to `LOAD_WAIT`. `WB_WB_EN`=0 next cycle.
- In `IDLE` with `MEM_valid`=0 → `WB_WB_EN`=0 next cycle. `WB_Dest`/`WB_Value` hold.
- In `LOAD_WAIT`:
  - `MEM_valid` is ignored.
  - Counter increments each cycle.
  - `mem_rvalid`=1 → next cycle write latched dest with `mem_rdata`, go to `IDLE`.
  - Counter reaches `TIMEOUT_CYCLES`-1 with `mem_rvalid`=0 → next cycle `load_err`=1, `WB_WB_EN`=0, go to `IDLE`. The write is dropped.
- `mem_rvalid` outside a pending load is ignored.
- `WB_WB_EN` is high for at most one cycle per retired instruction.

## Timing
- Latency is 1 cycle from acceptance (or from `mem_rvalid` in `LOAD_WAIT`) to the write-back outputs. All outputs are registered.
- `stall` rises the cycle after a load is accepted without data. It falls the cycle after `mem_rvalid` or timeout. That is the same edge at which the write-back outputs update.
- Data arriving on the timeout cycle wins: the write is performed and `load_err` stays 0.
- Asynchronous reset mid-`LOAD_WAIT`: return to `IDLE`, drop the pending write, clear all outputs.
- Counter width is 8 bits and never wraps; it saturates at the timeout compare.

## Configuration
- Macro `WB_FORWARD_EN`.
- Defined: adds ports `fwd_pend` (out, 1) and `fwd_pend_dest` (out, 4).
  - `fwd_pend`=1 while in `LOAD_WAIT` (same as `stall`).
  - `fwd_pend_dest` = latched destination, so the hazard logic can stall dependent instructions.
  - Both are 0 at reset and in `IDLE`.
- Undefined: ports absent, no extra logic.

## Structure
- Shared package `arm_pkg`: `REG_ADDR_W`=4, `DATA_W`=32, enum `wb_state_t` {`IDLE`, `LOAD_WAIT`}.
- One sub-module, `wb_timeout_counter`: clear, enable and expiry flag, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Reset released, `MEM_valid`=1, `MEM_R_EN`=0, `MEM_WB_EN`=1, `MEM_Dest`=3, `ALU_result`=0x0000_0010 → next cycle `WB_WB_EN`=1, `WB_Dest`=3, `WB_Value`=0x10, `stall`=0.
- Load with `mem_rvalid`=1 same cycle, `mem_rdata`=0xDEAD_BEEF, `MEM_Dest`=7 → next cycle write R7=0xDEADBEEF, `stall` never high.
- Load to R5, `mem_rvalid` after 3 cycles with 0x1234 → `stall` high 3 cycles. `MEM_valid` pulses during the wait are ignored. Then a single write R5=0x1234.
- Load, no `mem_rvalid` for 15 cycles → `load_err` pulse, `WB_WB_EN` never 1, state `IDLE`. Repeat with `mem_rvalid` on cycle 15 → write performed, no `load_err`.
- `rst` asserted 2 cycles into `LOAD_WAIT` → all outputs 0 immediately. A late `mem_rvalid` after release causes no write.
- With `WB_FORWARD_EN`: pending load to R9 → `fwd_pend`=1, `fwd_pend_dest`=9 until completion, then 0.
